// File: rtl/rr_stats.sv
// RR-interval statistics: rejects out-of-range intervals, keeps a circular history of accepted
// RR periods, and publishes per-beat records with running avg/min/max and rhythm flags.
module rr_stats #(
  parameter int unsigned CTR_WIDTH   = 22,
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned RR_MIN      = 72,
  parameter int unsigned RR_MAX      = 1080,
  parameter int unsigned TH_TACHY    = 216,
  parameter int unsigned TH_BRADY    = 360,
  parameter int unsigned IRREG_SHIFT = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce,
  input  logic [CTR_WIDTH-1:0] i_rr_period,
  input  logic                 i_rr_period_updated,
  input  logic [CTR_WIDTH-1:0] i_r_peak_location,
  output logic [CTR_WIDTH-1:0] o_rr_avg,
  output logic                 o_rr_avg_valid,
  output logic [CTR_WIDTH-1:0] o_rr_min,
  output logic [CTR_WIDTH-1:0] o_rr_max,
  output logic [15:0]          o_beat_count,
  output logic [7:0]           o_artefact_count,
  output logic                 o_rec_valid,
  input  logic                 i_rec_ready,
  output logic [CTR_WIDTH-1:0] o_rec_rr,
  output logic [CTR_WIDTH-1:0] o_rec_loc,
  output logic [3:0]           o_rec_flags,
  output logic                 o_overflow
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned SUM_W = CTR_WIDTH + DEPTH_LOG2;

  localparam logic [CTR_WIDTH-1:0]  RrMin    = CTR_WIDTH'(RR_MIN);
  localparam logic [CTR_WIDTH-1:0]  RrMax    = CTR_WIDTH'(RR_MAX);
  localparam logic [CTR_WIDTH-1:0]  TachyTh  = CTR_WIDTH'(TH_TACHY);
  localparam logic [CTR_WIDTH-1:0]  BradyTh  = CTR_WIDTH'(TH_BRADY);
  localparam logic [DEPTH_LOG2:0]   FillFull = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] ScanLast = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StWrite, StScan, StPublish} state_e;

  state_e state_q, state_d;

  logic                  pend_valid_q;
  logic [CTR_WIDTH-1:0]  pend_rr_q, pend_loc_q;
  logic [CTR_WIDTH-1:0]  cur_rr_q, cur_loc_q;
  logic                  artefact_q, irreg_q;
  logic [CTR_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q;
  logic [SUM_W-1:0]      sum_q;
  logic [DEPTH_LOG2-1:0] scan_idx_q;
  logic [CTR_WIDTH-1:0]  scan_min_q, scan_max_q;

  logic [CTR_WIDTH-1:0]  avg_q, min_q, max_q, rec_rr_q, rec_loc_q;
  logic                  avg_valid_q, rec_valid_q, overflow_q;
  logic [15:0]           beat_cnt_q;
  logic [7:0]            art_cnt_q;
  logic [3:0]            rec_flags_q;

  logic                   artefact, irregular, new_valid, tachy, brady, rec_xfer, in_fill;
  logic signed [CTR_WIDTH:0] rr_diff;
  logic [CTR_WIDTH:0]     abs_diff;
  logic [SUM_W-1:0]       sum_next;
  logic [CTR_WIDTH-1:0]   new_avg, scan_val;

  always_comb begin
    artefact  = (cur_rr_q < RrMin) || (cur_rr_q > RrMax);
    rr_diff   = $signed({1'b0, cur_rr_q}) - $signed({1'b0, avg_q});
    abs_diff  = rr_diff[CTR_WIDTH] ? -rr_diff : rr_diff;
    // Irregularity is judged against the average before this beat enters the buffer.
    irregular = avg_valid_q && (abs_diff > {1'b0, avg_q >> IRREG_SHIFT});
    sum_next  = sum_q + SUM_W'(cur_rr_q)
              - ((fill_q == FillFull) ? SUM_W'(mem_q[wr_ptr_q]) : '0);
    new_avg   = sum_q[DEPTH_LOG2 +: CTR_WIDTH];
    new_valid = (fill_q == FillFull);
    tachy     = new_valid && (new_avg < TachyTh);
    brady     = new_valid && (new_avg > BradyTh);
    rec_xfer  = rec_valid_q && i_rec_ready;
    in_fill   = ({1'b0, scan_idx_q} < fill_q);
    scan_val  = mem_q[scan_idx_q];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pend_valid_q || i_rr_period_updated) state_d = StCheck;
      StCheck:   state_d = artefact ? StPublish : StWrite;
      StWrite:   state_d = StScan;
      StScan:    if (scan_idx_q == ScanLast) state_d = StPublish;
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else if (i_ce) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_valid_q <= 1'b0;
      pend_rr_q    <= '0;
      pend_loc_q   <= '0;
      cur_rr_q     <= '0;
      cur_loc_q    <= '0;
      artefact_q   <= 1'b0;
      irreg_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      sum_q        <= '0;
      scan_idx_q   <= '0;
      scan_min_q   <= '0;
      scan_max_q   <= '0;
      avg_q        <= '0;
      avg_valid_q  <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      beat_cnt_q   <= '0;
      art_cnt_q    <= '0;
      rec_valid_q  <= 1'b0;
      rec_rr_q     <= '0;
      rec_loc_q    <= '0;
      rec_flags_q  <= '0;
      overflow_q   <= 1'b0;
    end else if (i_ce) begin
      // Intake: IDLE serves the pending slot first; a strobe arriving then refills it.
      if (state_q == StIdle) begin
        if (pend_valid_q) begin
          cur_rr_q     <= pend_rr_q;
          cur_loc_q    <= pend_loc_q;
          pend_valid_q <= i_rr_period_updated;
          if (i_rr_period_updated) begin
            pend_rr_q  <= i_rr_period;
            pend_loc_q <= i_r_peak_location;
          end
        end else if (i_rr_period_updated) begin
          cur_rr_q  <= i_rr_period;
          cur_loc_q <= i_r_peak_location;
        end
      end else if (i_rr_period_updated) begin
        if (!pend_valid_q) begin
          pend_valid_q <= 1'b1;
          pend_rr_q    <= i_rr_period;
          pend_loc_q   <= i_r_peak_location;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      if (rec_xfer) rec_valid_q <= 1'b0;

      unique case (state_q)
        StCheck: begin
          artefact_q <= artefact;
          irreg_q    <= irregular;
        end
        StWrite: begin
          mem_q[wr_ptr_q] <= cur_rr_q;
          sum_q           <= sum_next;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
          if (fill_q != FillFull) fill_q <= fill_q + 1'b1;
          scan_idx_q <= '0;
          scan_min_q <= '1;
          scan_max_q <= '0;
        end
        StScan: begin
          if (in_fill) begin
            if (scan_val < scan_min_q) scan_min_q <= scan_val;
            if (scan_val > scan_max_q) scan_max_q <= scan_val;
          end
          scan_idx_q <= scan_idx_q + 1'b1;
        end
        StPublish: begin
          avg_q       <= new_avg;
          avg_valid_q <= new_valid;
          if (artefact_q) begin
            if (art_cnt_q != 8'hFF) art_cnt_q <= art_cnt_q + 8'd1;
          end else begin
            if (beat_cnt_q != 16'hFFFF) beat_cnt_q <= beat_cnt_q + 16'd1;
            min_q <= scan_min_q;
            max_q <= scan_max_q;
          end
          if (!rec_valid_q || i_rec_ready) begin
            rec_valid_q <= 1'b1;
            rec_rr_q    <= cur_rr_q;
            rec_loc_q   <= cur_loc_q;
            rec_flags_q <= artefact_q ? 4'b0001 : {brady, tachy, irreg_q, 1'b0};
          end else begin
            overflow_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rr_avg         = avg_q;
  assign o_rr_avg_valid   = avg_valid_q;
  assign o_rr_min         = min_q;
  assign o_rr_max         = max_q;
  assign o_beat_count     = beat_cnt_q;
  assign o_artefact_count = art_cnt_q;
  assign o_rec_valid      = rec_valid_q;
  assign o_rec_rr         = rec_rr_q;
  assign o_rec_loc        = rec_loc_q;
  assign o_rec_flags      = rec_flags_q;
  assign o_overflow       = overflow_q;

endmodule

// File: tb/tb_rr_stats.sv
// Bench for rr_stats: directed vector table, hand sequences for handshake/pending corner cases,
// and randomized beats checked against a queue-based reference model.
module tb_rr_stats;
  localparam int CW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ce, upd, rec_ready;
  logic [CW-1:0] rr_in, loc_in;
  logic [CW-1:0] avg, mn, mx, rec_rr, rec_loc;
  logic          avg_valid, rec_valid, overflow;
  logic [15:0]   beats;
  logic [7:0]    arts;
  logic [3:0]    flags;

  rr_stats dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ce                (ce),
    .i_rr_period         (rr_in),
    .i_rr_period_updated (upd),
    .i_r_peak_location   (loc_in),
    .o_rr_avg            (avg),
    .o_rr_avg_valid      (avg_valid),
    .o_rr_min            (mn),
    .o_rr_max            (mx),
    .o_beat_count        (beats),
    .o_artefact_count    (arts),
    .o_rec_valid         (rec_valid),
    .i_rec_ready         (rec_ready),
    .o_rec_rr            (rec_rr),
    .o_rec_loc           (rec_loc),
    .o_rec_flags         (flags),
    .o_overflow          (overflow)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: the accepted history as a plain FIFO of at most 8 RR values.
  int hist[$];
  int m_beats, m_arts, m_flags;

  function automatic int h_sum();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  function automatic int h_min();
    int m;
    if (hist.size() == 0) return 0;
    m = hist[0];
    foreach (hist[i]) if (hist[i] < m) m = hist[i];
    return m;
  endfunction

  function automatic int h_max();
    int m = 0;
    foreach (hist[i]) if (hist[i] > m) m = hist[i];
    return m;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_beats = 0;
    m_arts  = 0;
    m_flags = 0;
  endtask

  task automatic model_step(input int rr);
    int  pre_avg, d, a;
    bit  pre_valid;
    pre_avg   = h_sum() / 8;
    pre_valid = (hist.size() == 8);
    if (rr < 72 || rr > 1080) begin
      m_flags = 1;
      if (m_arts < 255) m_arts++;
    end else begin
      d = rr - pre_avg;
      if (d < 0) d = -d;
      hist.push_back(rr);
      if (hist.size() > 8) void'(hist.pop_front());
      if (m_beats < 65535) m_beats++;
      a = h_sum() / 8;
      m_flags = 0;
      if (pre_valid && d > pre_avg / 8) m_flags |= 2;
      if (hist.size() == 8 && a < 216) m_flags |= 4;
      if (hist.size() == 8 && a > 360) m_flags |= 8;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_avg"},   avg,       h_sum() / 8);
    check({tag, "_valid"}, avg_valid, int'(hist.size() == 8));
    check({tag, "_min"},   mn,        h_min());
    check({tag, "_max"},   mx,        h_max());
    check({tag, "_beats"}, beats,     m_beats);
    check({tag, "_arts"},  arts,      m_arts);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg"},      avg,       0);
    check({tag, "_valid"},    avg_valid, 0);
    check({tag, "_min"},      mn,        0);
    check({tag, "_max"},      mx,        0);
    check({tag, "_beats"},    beats,     0);
    check({tag, "_arts"},     arts,      0);
    check({tag, "_recv"},     rec_valid, 0);
    check({tag, "_recrr"},    rec_rr,    0);
    check({tag, "_recloc"},   rec_loc,   0);
    check({tag, "_flags"},    flags,     0);
    check({tag, "_overflow"}, overflow,  0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b1;
    upd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge; drives a one-cycle strobe.
  task automatic strobe(input int rr, input int loc);
    ce     = 1'b1;
    rr_in  = CW'(rr);
    loc_in = CW'(loc);
    upd    = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  int cap_rr, cap_loc, cap_flags;

  task automatic wait_rec(input bit rand_ce);
    int n = 0;
    while (!rec_valid && n < 200) begin
      ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      n++;
    end
    ce = 1'b1;
    check("rec_arrives", rec_valid, 1);
    cap_rr    = rec_rr;
    cap_loc   = rec_loc;
    cap_flags = flags;
  endtask

  task automatic do_beat(input int rr, input int loc, input bit rand_ce);
    strobe(rr, loc);
    wait_rec(rand_ce);
    model_step(rr);
    @(negedge clk);
  endtask

  typedef struct {
    int rr;
    int flags;
    int avg;
    int valid;
    int mn;
    int mx;
  } vec_t;

  vec_t vecs[19];
  int   got_rr[$];

  initial begin
    vecs[0]  = '{300, 0, 37, 0, 300, 300};
    vecs[1]  = '{300, 0, 75, 0, 300, 300};
    vecs[2]  = '{300, 0, 112, 0, 300, 300};
    vecs[3]  = '{300, 0, 150, 0, 300, 300};
    vecs[4]  = '{300, 0, 187, 0, 300, 300};
    vecs[5]  = '{300, 0, 225, 0, 300, 300};
    vecs[6]  = '{300, 0, 262, 0, 300, 300};
    vecs[7]  = '{300, 0, 300, 1, 300, 300};
    vecs[8]  = '{400, 2, 312, 1, 300, 400};
    vecs[9]  = '{50, 1, 312, 1, 300, 400};
    vecs[10] = '{2000, 1, 312, 1, 300, 400};
    vecs[11] = '{200, 2, 300, 1, 200, 400};
    vecs[12] = '{200, 2, 287, 1, 200, 400};
    vecs[13] = '{200, 2, 275, 1, 200, 400};
    vecs[14] = '{200, 2, 262, 1, 200, 400};
    vecs[15] = '{200, 2, 250, 1, 200, 400};
    vecs[16] = '{200, 2, 237, 1, 200, 400};
    vecs[17] = '{200, 2, 225, 1, 200, 400};
    vecs[18] = '{200, 4, 200, 1, 200, 200};

    rst = 1'b1; ce = 1'b1; upd = 1'b0; rec_ready = 1'b1; rr_in = '0; loc_in = '0;
    @(negedge clk);
    do_reset();
    check_zero("reset");

    // Directed table: fill, irregular beat, artefacts, drift into tachycardia.
    for (int i = 0; i < 19; i++) begin
      do_beat(vecs[i].rr, 1000 * (i + 1), 1'b0);
      check($sformatf("vec%0d_rr", i),    cap_rr,    vecs[i].rr);
      check($sformatf("vec%0d_loc", i),   cap_loc,   1000 * (i + 1));
      check($sformatf("vec%0d_flags", i), cap_flags, vecs[i].flags);
      check($sformatf("vec%0d_avg", i),   avg,       vecs[i].avg);
      check($sformatf("vec%0d_valid", i), avg_valid, vecs[i].valid);
      check($sformatf("vec%0d_min", i),   mn,        vecs[i].mn);
      check($sformatf("vec%0d_max", i),   mx,        vecs[i].mx);
    end
    check("table_beats", beats, 17);
    check("table_arts", arts, 2);
    check("table_ovf", overflow, 0);

    // Host stalls: first record must be held, second dropped, stats still advance.
    rec_ready = 1'b0;
    strobe(210, 50000);
    wait_rec(1'b0);
    model_step(210);
    check("held_first_flags", cap_flags, m_flags);
    strobe(220, 51000);
    model_step(220);
    repeat (16) @(negedge clk);
    check("held_rr", rec_rr, 210);
    check("held_loc", rec_loc, 50000);
    check("held_flags", flags, 4);
    check("held_valid", rec_valid, 1);
    check("held_ovf", overflow, 1);
    check("held_beats", beats, 19);
    check_stats("held");
    rec_ready = 1'b1;
    @(negedge clk);
    check("held_drained", rec_valid, 0);

    // Strobes at cycles 0, 2, 4: second goes to pending, third is dropped.
    do_reset();
    strobe(300, 100);
    @(negedge clk);
    strobe(310, 200);
    @(negedge clk);
    strobe(320, 300);
    for (int c = 0; c < 60; c++) begin
      if (rec_valid) got_rr.push_back(int'(rec_rr));
      @(negedge clk);
    end
    model_step(300);
    model_step(310);
    check("pend_count", got_rr.size(), 2);
    if (got_rr.size() == 2) begin
      check("pend_first", got_rr[0], 300);
      check("pend_second", got_rr[1], 310);
    end
    check("pend_ovf", overflow, 1);
    check_stats("pend");

    // Reset while the history scan is in progress.
    strobe(400, 400);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_zero("scan_rst");
    do_beat(500, 777, 1'b0);
    check("post_rst_rr", cap_rr, 500);
    check("post_rst_flags", cap_flags, m_flags);
    check_stats("post_rst");

    // Randomized beats around a few rhythm bases, with clock-enable gaps.
    for (int i = 0; i < 60; i++) begin
      int base, rr, loc;
      case ((i / 10) % 3)
        0:       base = 160;
        1:       base = 300;
        default: base = 480;
      endcase
      rr  = base + int'($urandom_range(0, 60)) - 30;
      if ($urandom_range(0, 7) == 0) rr = ($urandom_range(0, 1) != 0) ? 40 : 1500;
      loc = int'($urandom_range(0, 4000000));
      do_beat(rr, loc, 1'b1);
      check($sformatf("rnd%0d_rr", i),    cap_rr,    rr);
      check($sformatf("rnd%0d_loc", i),   cap_loc,   loc);
      check($sformatf("rnd%0d_flags", i), cap_flags, m_flags);
      check_stats($sformatf("rnd%0d", i));
    end
    check("rnd_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
